// File: rtl/disk_pkg.sv
// Shared types and helpers for the multi-drive disk track loader.
package disk_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        FLUSH = 2'd2
    } state_t;

    localparam int SECTOR_BYTES = 512;
    localparam int LBA_MAX_W    = 64;

    // First SD sector of a track; full-width product so large tracks never wrap.
    function automatic logic [LBA_MAX_W-1:0] track_lba(input logic [31:0] track,
                                                       input int unsigned secs);
        return LBA_MAX_W'(track) * LBA_MAX_W'(secs);
    endfunction

endpackage

// File: rtl/sd_sector_seq.sv
// Ack-edge sequencer for one multi-sector SD transfer: walks the LBA and the slot
// sector index, and drops the request once the last sector's ack has risen.
module sd_sector_seq #(
    parameter int SECS  = 13,
    parameter int LBA_W = 32,
    parameter int SEC_W = 4
) (
    input  logic             clk_sys,
    input  logic             reset,
    input  logic             en,
    input  logic             start,
    input  logic [LBA_W-1:0] start_lba,
    input  logic             ack,
    output logic [LBA_W-1:0] lba,
    output logic [SEC_W-1:0] sec,
    output logic             req,
    output logic             fall,
    output logic             done
);

    logic ack_q;
    logic rise;

    assign rise = en & ack & ~ack_q;
    assign fall = en & ~ack & ack_q;
    assign done = fall & ~req;

    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            ack_q <= 1'b0;
            lba   <= '0;
            sec   <= '0;
            req   <= 1'b0;
        end else begin
            ack_q <= ack;
            if (start) begin
                lba <= start_lba;
                sec <= '0;
                req <= 1'b1;
            end else begin
                if (rise) begin
                    lba <= lba + LBA_W'(1);
                    if (sec == SEC_W'(SECS - 1))
                        req <= 1'b0;
                end
                if (fall)
                    sec <= sec + SEC_W'(1);
            end
        end
    end

endmodule

// File: rtl/disk_track_loader.sv
// Streams each drive's requested track from the HPS SD interface into that drive's
// track RAM slot. Dirty-slot write-back is enabled by DISK_TRACK_LOADER_WRITEBACK_EN.
module disk_track_loader
    import disk_pkg::*;
#(
    parameter int DRIVES         = 2,
    parameter int SECS_PER_TRACK = 13,
    parameter int TRACK_BITS     = 6,
    parameter int LBA_W          = 32,
    localparam int DRV_W         = (DRIVES > 1) ? $clog2(DRIVES) : 1,
    localparam int SEC_W         = $clog2(SECS_PER_TRACK)
) (
    input  logic                         clk_sys,
    input  logic                         reset,
    input  logic [DRIVES*TRACK_BITS-1:0] track_req,
    input  logic [DRIVES-1:0]            img_mounted,
    input  logic [DRIVES-1:0]            img_present,
    input  logic [DRIVES-1:0]            track_dirty,
    output logic [LBA_W-1:0]             sd_lba,
    output logic [DRIVES-1:0]            sd_rd,
    output logic [DRIVES-1:0]            sd_wr,
    input  logic [DRIVES-1:0]            sd_ack,
    output logic [DRV_W-1:0]             ram_drive,
    output logic [SEC_W-1:0]             ram_sec,
    output logic [DRIVES-1:0]            dirty_clr,
    output logic                         cpu_wait,
    output logic                         busy
);

`ifdef DISK_TRACK_LOADER_WRITEBACK_EN
    localparam bit WB_EN = 1'b1;
`else
    localparam bit WB_EN = 1'b0;
`endif

    state_t state, state_n;
    logic [DRV_W-1:0]                   drv;
    logic [DRIVES-1:0]                  valid, mnt_pend, pending;
    logic [DRIVES-1:0][TRACK_BITS-1:0]  trq, cur_track;
    logic [DRV_W-1:0]                   sel;
    logic                               any_pend, flush_need;
    logic                               take, relatch, wait_set, seq_start;
    logic [LBA_W-1:0]                   start_lba;
    logic                               seq_req, seq_fall, seq_done;

    assign trq       = track_req;
    assign busy      = (state != IDLE);
    assign ram_drive = drv;

    always_comb begin
        pending  = '0;
        sel      = '0;
        any_pend = 1'b0;
        for (int d = 0; d < DRIVES; d++)
            pending[d] = ~valid[d] | (trq[d] != cur_track[d]);
        for (int d = DRIVES - 1; d >= 0; d--) begin
            if (pending[d]) begin
                sel      = DRV_W'(d);
                any_pend = 1'b1;
            end
        end
        flush_need = WB_EN & valid[sel] & track_dirty[sel] & img_present[sel];
    end

    always_comb begin
        state_n   = state;
        take      = 1'b0;
        relatch   = 1'b0;
        wait_set  = 1'b0;
        seq_start = 1'b0;
        start_lba = '0;
        case (state)
            IDLE: begin
                if (any_pend) begin
                    if (flush_need) begin
                        // Write back the old track before the slot is overwritten.
                        state_n   = FLUSH;
                        seq_start = 1'b1;
                        start_lba = LBA_W'(track_lba(32'(cur_track[sel]), SECS_PER_TRACK));
                    end else begin
                        take = 1'b1;
                        if (img_present[sel]) begin
                            state_n   = LOAD;
                            seq_start = 1'b1;
                            wait_set  = 1'b1;
                            start_lba = LBA_W'(track_lba(32'(trq[sel]), SECS_PER_TRACK));
                        end
                    end
                end
            end
            LOAD: begin
                if (seq_done)
                    state_n = IDLE;
            end
            FLUSH: begin
                if (seq_done) begin
                    relatch   = 1'b1;
                    state_n   = LOAD;
                    seq_start = 1'b1;
                    wait_set  = 1'b1;
                    start_lba = LBA_W'(track_lba(32'(trq[drv]), SECS_PER_TRACK));
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_comb begin
        sd_rd = '0;
        sd_wr = '0;
        for (int d = 0; d < DRIVES; d++) begin
            sd_rd[d] = (state == LOAD)  & seq_req & (drv == DRV_W'(d));
            sd_wr[d] = (state == FLUSH) & seq_req & (drv == DRV_W'(d)) & WB_EN;
        end
    end

    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            drv       <= '0;
            valid     <= '0;
            mnt_pend  <= '0;
            cur_track <= '0;
            cpu_wait  <= 1'b0;
            dirty_clr <= '0;
        end else begin
            state     <= state_n;
            dirty_clr <= '0;
            if (state == IDLE && any_pend)
                drv <= sel;
            if (take) begin
                cur_track[sel] <= trq[sel];
                valid[sel]     <= 1'b1;
            end
            if (relatch) begin
                cur_track[drv] <= trq[drv];
                valid[drv]     <= 1'b1;
                dirty_clr[drv] <= 1'b1;
            end
            if (wait_set)
                cpu_wait <= 1'b0 | 1'b1;
            else if (state == LOAD && seq_fall)
                cpu_wait <= 1'b0;
            // A remount invalidates the slot; this overrides a same-cycle latch above.
            for (int d = 0; d < DRIVES; d++) begin
                if (img_mounted[d])
                    mnt_pend[d] <= 1'b1;
                else if (mnt_pend[d]) begin
                    mnt_pend[d] <= 1'b0;
                    valid[d]    <= 1'b0;
                end
            end
        end
    end

    sd_sector_seq #(
        .SECS  (SECS_PER_TRACK),
        .LBA_W (LBA_W),
        .SEC_W (SEC_W)
    ) u_seq (
        .clk_sys   (clk_sys),
        .reset     (reset),
        .en        (state != IDLE),
        .start     (seq_start),
        .start_lba (start_lba),
        .ack       (sd_ack[drv]),
        .lba       (sd_lba),
        .sec       (ram_sec),
        .req       (seq_req),
        .fall      (seq_fall),
        .done      (seq_done)
    );

endmodule
